// File: rtl/jstk_direction_decoder.sv
// PmodJSTK direction decoder: paced poll requests, packet latch, per-direction
// hysteresis and N-sample debounce, press pulses and link-loss detection.
module jstk_direction_decoder #(
  parameter int POLL_CYCLES    = 500000,
  parameter int TIMEOUT_CYCLES = 250000,
  parameter int HI_ON          = 520,
  parameter int HI_OFF         = 500,
  parameter int LO_ON          = 450,
  parameter int LO_OFF         = 470,
  parameter int DEB_SAMPLES    = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pkt_valid_i,
  input  logic [39:0] pkt_data_i,
  output logic        snd_rec_o,
  output logic [3:0]  dir_o,
  output logic [3:0]  dir_pulse_o,
  output logic [2:0]  buttons_o,
  output logic [9:0]  axis_a_o,
  output logic [9:0]  axis_b_o,
  output logic        stale_o
);

  localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [9:0] HI_ON_V  = 10'(HI_ON);
  localparam logic [9:0] HI_OFF_V = 10'(HI_OFF);
  localparam logic [9:0] LO_ON_V  = 10'(LO_ON);
  localparam logic [9:0] LO_OFF_V = 10'(LO_OFF);
  localparam logic [3:0] DEB_V    = 4'(DEB_SAMPLES);

  logic [PW-1:0]   poll_q, poll_d;
  logic            snd_rec_q, snd_rec_d;
  logic            armed_q, armed_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            stale_q, stale_d;
  logic [3:0]      raw_q, raw_d;
  logic [3:0]      dir_q, dir_d;
  logic [3:0]      dir_pulse_q, dir_pulse_d;
  logic [3:0][3:0] cnt_q, cnt_d;
  logic [2:0]      buttons_q, buttons_d;
  logic [9:0]      axis_a_q, axis_a_d;
  logic [9:0]      axis_b_q, axis_b_d;

  logic [9:0] pkt_a, pkt_b;
  logic [3:0] inc;

  assign pkt_a = {pkt_data_i[25:24], pkt_data_i[39:32]};
  assign pkt_b = {pkt_data_i[9:8], pkt_data_i[23:16]};

  always_comb begin
    poll_d      = poll_q;
    snd_rec_d   = 1'b0;
    armed_d     = armed_q;
    tcnt_d      = tcnt_q;
    stale_d     = stale_q;
    raw_d       = raw_q;
    dir_d       = dir_q;
    cnt_d       = cnt_q;
    buttons_d   = buttons_q;
    axis_a_d    = axis_a_q;
    axis_b_d    = axis_b_q;
    inc         = 4'd0;

    if (poll_q == POLL_LAST) begin
      poll_d    = '0;
      snd_rec_d = 1'b1;
    end else begin
      poll_d = poll_q + 1'b1;
    end

    if (pkt_valid_i) begin
      axis_a_d  = pkt_a;
      axis_b_d  = pkt_b;
      buttons_d = pkt_data_i[2:0];
      // Bit order {up, down, left, right}; each raw bit holds inside its band.
      raw_d[3] = raw_q[3] ? (pkt_a > HI_OFF_V)  : (pkt_a > HI_ON_V);
      raw_d[2] = raw_q[2] ? (pkt_a <= LO_OFF_V) : (pkt_a <= LO_ON_V);
      raw_d[1] = raw_q[1] ? (pkt_b <= LO_OFF_V) : (pkt_b <= LO_ON_V);
      raw_d[0] = raw_q[0] ? (pkt_b > HI_OFF_V)  : (pkt_b > HI_ON_V);
      for (int i = 0; i < 4; i++) begin
        if (raw_d[i] != dir_q[i]) begin
          inc = cnt_q[i] + 4'd1;
          if (inc == DEB_V) begin
            dir_d[i] = raw_d[i];
            cnt_d[i] = 4'd0;
          end else begin
            cnt_d[i] = inc;
          end
        end else begin
          cnt_d[i] = 4'd0;
        end
      end
      stale_d = 1'b0;
    end

    // A new request re-arms even when a packet lands in the same cycle.
    if (snd_rec_q) begin
      armed_d = 1'b1;
      tcnt_d  = '0;
    end else if (pkt_valid_i) begin
      armed_d = 1'b0;
    end else if (armed_q) begin
      if (tcnt_q == TOUT_LAST) begin
        armed_d = 1'b0;
        stale_d = 1'b1;
        dir_d   = 4'd0;
        cnt_d   = '0;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end

    dir_pulse_d = dir_d & ~dir_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      poll_q      <= '0;
      snd_rec_q   <= 1'b0;
      armed_q     <= 1'b0;
      tcnt_q      <= '0;
      stale_q     <= 1'b0;
      raw_q       <= 4'd0;
      dir_q       <= 4'd0;
      dir_pulse_q <= 4'd0;
      cnt_q       <= '0;
      buttons_q   <= 3'd0;
      axis_a_q    <= 10'd0;
      axis_b_q    <= 10'd0;
    end else begin
      poll_q      <= poll_d;
      snd_rec_q   <= snd_rec_d;
      armed_q     <= armed_d;
      tcnt_q      <= tcnt_d;
      stale_q     <= stale_d;
      raw_q       <= raw_d;
      dir_q       <= dir_d;
      dir_pulse_q <= dir_pulse_d;
      cnt_q       <= cnt_d;
      buttons_q   <= buttons_d;
      axis_a_q    <= axis_a_d;
      axis_b_q    <= axis_b_d;
    end
  end

  assign snd_rec_o   = snd_rec_q;
  assign dir_o       = dir_q;
  assign dir_pulse_o = dir_pulse_q;
  assign buttons_o   = buttons_q;
  assign axis_a_o    = axis_a_q;
  assign axis_b_o    = axis_b_q;
  assign stale_o     = stale_q;

endmodule
